// File: rtl/gf2n_iterative_multiplier.sv
// Multi-lane GF(2^N) MSB-first shift-and-add multiplier with a shared IDLE/RUN/DONE sequencer.
// Define GF_MUL_ACCUM_EN to add a per-lane multiply-accumulate register (sum) and its acc_clr port.
module gf2n_iterative_multiplier #(
    parameter int N = 4,
    parameter int LANES = 2,
    parameter logic [N-1:0] POLY = 4'b0011
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               op_mode,
    input  logic [LANES*N-1:0] a,
    input  logic [LANES*N-1:0] b,
    output logic               out_valid,
    input  logic               out_ready,
`ifdef GF_MUL_ACCUM_EN
    input  logic               acc_clr,
`endif
    output logic [LANES*N-1:0] p
);
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                   state;
    logic [CW-1:0]            cnt;
    logic [LANES-1:0][N-1:0]  op_a;
    logic [LANES-1:0][N-1:0]  op_b;
    logic [LANES-1:0][N-1:0]  acc;
    logic [LANES-1:0][N-1:0]  acc_nxt;
    logic [LANES-1:0][N-1:0]  p_q;

    function automatic logic [N-1:0] xtime(input logic [N-1:0] v);
        return {v[N-2:0], 1'b0} ^ (v[N-1] ? POLY : '0);
    endfunction

    always_comb begin
        acc_nxt = '0;
        for (int i = 0; i < LANES; i++)
            acc_nxt[i] = xtime(acc[i]) ^ (op_b[i][cnt] ? op_a[i] : '0);
    end

`ifdef GF_MUL_ACCUM_EN
    logic [LANES-1:0][N-1:0] sum;
    logic [LANES-1:0][N-1:0] sum_eff;

    // A clear on the same edge as a result load means the result starts a fresh accumulation.
    assign sum_eff = acc_clr ? '0 : sum;

    always_ff @(posedge clk) begin
        if (!rst_n)
            sum <= '0;
        else if (acc_clr)
            sum <= '0;
        else if (out_valid && out_ready)
            sum <= sum ^ acc;
    end
`endif

    assign in_ready = (state == IDLE);
    assign p        = p_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            op_a      <= '0;
            op_b      <= '0;
            acc       <= '0;
            p_q       <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_a  <= a;
                        op_b  <= op_mode ? a : b;
                        acc   <= '0;
                        cnt   <= CW'(N - 1);
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc <= acc_nxt;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
`ifdef GF_MUL_ACCUM_EN
                        p_q <= acc_nxt ^ sum_eff;
`else
                        p_q <= acc_nxt;
`endif
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
`ifdef GF_MUL_ACCUM_EN
                    else begin
                        p_q <= acc ^ sum_eff;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gf2n_iterative_multiplier.sv
// Directed, table-driven bench for gf2n_iterative_multiplier (N=4, LANES=2, x^4+x+1).
module tb_gf2n_iterative_multiplier;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic       op_mode;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] p;
`ifdef GF_MUL_ACCUM_EN
    logic       acc_clr;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    gf2n_iterative_multiplier #(.N(4), .LANES(2), .POLY(4'b0011)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .op_mode(op_mode),
        .a(a),
        .b(b),
        .out_valid(out_valid),
        .out_ready(out_ready),
`ifdef GF_MUL_ACCUM_EN
        .acc_clr(acc_clr),
`endif
        .p(p)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       mode;
        logic [7:0] exp;
        string      name;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Launch one operation with out_ready=1; verify latency, busy flag, result, and return to IDLE.
    task automatic run_op(input logic [7:0] va, input logic [7:0] vb, input logic m,
                          input logic [7:0] ex, input string nm);
        int lat;
        lat = 0;
        @(negedge clk);
        check({nm, "_in_ready"}, 32'(in_ready), 32'd1);
        a = va; b = vb; op_mode = m; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) check({nm, "_busy"}, 32'(in_ready), 32'd0);
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        check({nm, "_latency"}, 32'(lat), 32'd4);
        check({nm, "_p"}, 32'(p), 32'(ex));
        @(posedge clk);
        #1;
        check({nm, "_idle"}, {30'd0, out_valid, in_ready}, 32'b01);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'h23, 8'h87, 1'b0, 8'h39, "mul_basic"};
        vecs[1] = '{8'h2F, 8'h55, 1'b1, 8'h4A, "square"};
        vecs[2] = '{8'hD0, 8'h1B, 1'b0, 8'hD0, "zero_one"};
        vecs[3] = '{8'h85, 8'h86, 1'b0, 8'hCD, "mul_5x6_8x8"};
        vecs[4] = '{8'h97, 8'h9B, 1'b0, 8'hD4, "mul_7xB_9x9"};
        vecs[5] = '{8'hF0, 8'h1F, 1'b0, 8'hF0, "one_zero"};
        vecs[6] = '{8'h89, 8'h00, 1'b1, 8'hCD, "square_b0"};

        rst_n = 1'b0; in_valid = 1'b0; op_mode = 1'b0; a = '0; b = '0; out_ready = 1'b1;
`ifdef GF_MUL_ACCUM_EN
        acc_clr = 1'b1;
`endif
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_p", 32'(p), 32'd0);

        for (int i = 0; i < 7; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].mode, vecs[i].exp, vecs[i].name);

        // Backpressure: result held for 10 cycles, a new in_valid pulse is ignored.
        @(negedge clk);
        a = 8'h53; b = 8'h67; op_mode = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int k = 0; k < 20 && !out_valid; k++) begin
            @(posedge clk);
            #1;
        end
        begin
            int bad;
            bad = 0;
            for (int k = 0; k < 10; k++) begin
                if (k == 3) begin
                    a = 8'hFF; b = 8'hFF; in_valid = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
                @(posedge clk);
                #1;
                if (out_valid !== 1'b1 || p !== 8'hD9 || in_ready !== 1'b0) bad++;
            end
            check("backpressure_hold_bad_cycles", 32'(bad), 32'd0);
        end
        check("backpressure_p", 32'(p), 32'hD9);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("backpressure_release", {30'd0, out_valid, in_ready}, 32'b01);
        check("backpressure_p_retained", 32'(p), 32'hD9);
        repeat (3) @(posedge clk);
        #1;
        check("backpressure_no_extra_op", {30'd0, out_valid, in_ready}, 32'b01);

        // Reset in the second RUN cycle abandons the operation.
        @(negedge clk);
        a = 8'hFF; b = 8'hFF; op_mode = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        check("midreset_in_ready", 32'(in_ready), 32'd1);
        check("midreset_p", 32'(p), 32'd0);
        begin
            int seen;
            seen = 0;
            for (int k = 0; k < 8; k++) begin
                @(posedge clk);
                #1;
                if (out_valid) seen++;
            end
            check("midreset_no_out_valid", 32'(seen), 32'd0);
        end
        run_op(8'h23, 8'h87, 1'b0, 8'h39, "after_reset");

`ifdef GF_MUL_ACCUM_EN
        // Multiply-accumulate on lane 0; acc_clr had been held high so sum starts at zero.
        @(negedge clk);
        acc_clr = 1'b0;
        run_op(8'h03, 8'h07, 1'b0, 8'h09, "mac_first");
        run_op(8'h02, 8'h08, 1'b0, 8'h0A, "mac_second");
        @(negedge clk);
        acc_clr = 1'b1;
        @(negedge clk);
        acc_clr = 1'b0;
        run_op(8'h0F, 8'h0F, 1'b0, 8'h0A, "mac_after_clr");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
